// File: rtl/arith_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks: slice width,
// controller states and the counter-width helper.
package arith_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Minimum one bit so a single-slice build still has a legal counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit borrow-ripple subtractor built from 1-bit full-subtractor cells.
// Zero latency; no flow control.
module fsub1 (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

module nibble_sub4 (
    output logic [3:0] diff,
    output logic       bout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin
);
    logic [4:0] brw;

    assign brw[0] = bin;
    assign bout   = brw[4];

    for (genvar i = 0; i < 4; i++) begin : g_cell
        fsub1 u_cell (
            .d  (diff[i]),
            .bo (brw[i+1]),
            .a  (a[i]),
            .b  (b[i]),
            .bi (brw[i])
        );
    end
endmodule

// File: rtl/seq_sub_ctrl.sv
// Nibble-serial WIDTH-bit subtractor diff = a - b - bin, LSB nibble first; result valid N edges after acceptance.
// One operation in flight; the result is held in DONE until out_ready, and in_ready is high only in IDLE.
module seq_sub_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int N  = WIDTH / NIB;
    localparam int CW = cnt_width(N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, bout_q, bout_d, zero_q, zero_d;

    logic [NIB-1:0]   nd;
    logic             nb;
    logic [WIDTH-1:0] diff_sh;

    nibble_sub4 u_slice (
        .diff (nd),
        .bout (nb),
        .a    (a_q[NIB-1:0]),
        .b    (b_q[NIB-1:0]),
        .bin  (brw_q)
    );

    // New nibble enters at the top so after N slices the LSB nibble sits at bit 0.
    assign diff_sh = (diff_q >> NIB) | (WIDTH'(nd) << (WIDTH - NIB));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = diff_sh;
                a_d    = a_q >> NIB;
                b_d    = b_q >> NIB;
                brw_d  = nb;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    bout_d  = nb;
                    zero_d  = (diff_sh == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_seq_sub_ctrl.sv
// Bench for seq_sub_ctrl: scoreboard of expected results checked on each output transfer,
// plus per-scenario checks of latency, backpressure, busy behaviour and reset.
module tb_seq_sub_ctrl;
    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pushed = 0;
    int   n_aborted = 0;
    int   n_xfer = 0;

    seq_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Scoreboard: the transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            n_xfer++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: unexpected transfer diff=%h bout=%b zero=%b", diff, bout, zero);
            end else begin
                e = q.pop_front();
                if (diff !== e.diff || bout !== e.bout || zero !== e.zero) begin
                    n_fail++;
                    $display("FAIL sb_result: got diff=%h bout=%b zero=%b, want diff=%h bout=%b zero=%b",
                             diff, bout, zero, e.diff, e.bout, e.zero);
                end
            end
        end
    end

    // Drives one operand set until accepted and records its expected result.
    task automatic push_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        logic [WIDTH:0] full;
        exp_t e;
        logic rdy;
        int   t;
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        t = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            #1;
            t++;
            if (t > 100) begin
                n_checks++; n_fail++;
                $display("FAIL push_timeout: in_ready=%b, want 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        full = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, bi};
        e.diff = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.zero = (full[WIDTH-1:0] == '0);
        q.push_back(e);
        n_pushed++;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h bout=%b zero=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, diff, bout, zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push_op(16'h1234, 16'h0234, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early_valid: cycle %0d out_valid=%b, want 0", i, out_valid);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 16'h1000 || bout !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b in_ready=%b diff=%h bout=%b zero=%b, want 1 0 1000 0 0",
                     out_valid, in_ready, diff, bout, zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_borrow();
        push_op(16'h0000, 16'h0001, 1'b0);
        drain();
        n_checks++;
        if (diff !== 16'hFFFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_ripple: diff=%h bout=%b, want ffff 1", diff, bout);
        end
        push_op(16'h1000, 16'h0001, 1'b0);
        drain();
        n_checks++;
        if (diff !== 16'h0FFF || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_cross: diff=%h bout=%b, want 0fff 0", diff, bout);
        end
        push_op(16'h8000, 16'h7FFF, 1'b1);
        drain();
        n_checks++;
        if (diff !== 16'h0000 || bout !== 1'b0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_zero: diff=%h bout=%b zero=%b, want 0000 0 1", diff, bout, zero);
        end
        push_op(16'h0005, 16'h0005, 1'b1);
        drain();
        n_checks++;
        if (diff !== 16'hFFFF || bout !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_eq_bin: diff=%h bout=%b zero=%b, want ffff 1 0", diff, bout, zero);
        end
        push_op(16'h0000, 16'hFFFF, 1'b0);
        drain();
        n_checks++;
        if (diff !== 16'h0001 || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_zero_minus_max: diff=%h bout=%b, want 0001 1", diff, bout);
        end
        push_op(16'h0000, 16'hFFFF, 1'b1);
        drain();
        n_checks++;
        if (diff !== 16'h0000 || bout !== 1'b1 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_zero_minus_max_bin: diff=%h bout=%b zero=%b, want 0000 1 1", diff, bout, zero);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] hd;
        logic             hb, hz;
        int               t;
        out_ready = 1'b0;
        push_op(16'h4321, 16'h5678, 1'b0);
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_run_ready: in_ready=%b, want 0", in_ready);
            end
            @(posedge clk); #1; t++;
        end
        hd = diff; hb = bout; hz = zero;
        n_checks++;
        if (out_valid !== 1'b1 || hd !== 16'hECA9 || hb !== 1'b1 || hz !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: out_valid=%b diff=%h bout=%b zero=%b, want 1 eca9 1 0", out_valid, hd, hb, hz);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'(16'h2222 + i); b = 16'h0003; bin = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== hd || bout !== hb || zero !== hz) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b diff=%h bout=%b zero=%b, want 1 0 %h %b %b",
                         i, out_valid, in_ready, diff, bout, zero, hd, hb, hz);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b pending=%0d, want 0 1 0", out_valid, in_ready, q.size());
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b1;
        push_op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        n_aborted++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || diff !== '0 || in_ready !== 1'b1 || bout !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: out_valid=%b diff=%h in_ready=%b bout=%b zero=%b, want 0 0000 1 0 0",
                     out_valid, diff, in_ready, bout, zero);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_no_pulse: cycle %0d out_valid=%b, want 0", i, out_valid);
            end
        end
        push_op(16'hFFFF, 16'h0001, 1'b0);
        drain();
        n_checks++;
        if (diff !== 16'hFFFE || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_fresh: diff=%h bout=%b, want fffe 0", diff, bout);
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    push_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (n_xfer != n_pushed - n_aborted) begin
            n_fail++;
            $display("FAIL random_count: transfers=%0d, want %0d", n_xfer, n_pushed - n_aborted);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_midreset();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_sub_ctrl.md
Name: seq_sub_ctrl

Overview:
- Multi-cycle wide subtractor. Computes diff = a - b - bin for WIDTH-bit operands, one 4-bit nibble per clock, LSB nibble first.
- Each nibble goes through a 4-bit borrow-ripple slice. A registered borrow chains the slices across cycles.
- Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake.
- Sits between the operand source and the result consumer in the arithmetic datapath. It sequences the 4-bit subtractor slice.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, 4, slice width in bits; fixed, not to be overridden.
- N (localparam), WIDTH/NIB, number of slice cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  1 iff diff == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values (on the edge where rst=1): state=IDLE, out_valid=0, diff=0, bout=0, zero=0, counter=0, internal borrow=0.
- in_ready: decoded from state, 1 only in IDLE. It reads 1 in the first cycle after reset deasserts.
- States:
  - IDLE: when in_valid && in_ready, latch a_r=a, b_r=b, brw=bin, cnt=0, then go to RUN. Otherwise stay in IDLE.
  - RUN, on each edge:
    - Compute the slice {nd, nb} = a_r[3:0] - b_r[3:0] - brw.
    - diff_r <= {nd, diff_r[WIDTH-1:4]}.
    - a_r and b_r logically shift right by 4.
    - brw <= nb.
    - cnt <= cnt+1.
    - When cnt == N-1, go to DONE. On that same edge, bout <= nb and zero <= ({nd, diff_r[WIDTH-1:4]} == 0).
  - DONE: out_valid=1. diff, bout and zero are held stable while out_ready=0. When out_ready=1, go to IDLE (the transfer completes on that edge).
- Latency: operands accepted on edge k give out_valid=1 after edge k+N (4 cycles for WIDTH=16).
- Throughput: minimum N+2 cycles per operation. No overlap: a new operation cannot be accepted in the DONE cycle.
- Inputs while busy: in_valid in RUN or DONE is ignored. a, b and bin are not sampled again after acceptance, so input changes mid-operation have no effect.
- out_ready in IDLE or RUN: no effect.
- Reset mid-operation (rst=1 in RUN or DONE): abort, discard the partial result, return to IDLE with reset values. No out_valid pulse is produced.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - The slice uses per-bit borrow = (~a&b) | (~a&bin) | (b&bin) and difference bit = a^b^bin.
  - The result must equal (a - b - bin) mod 2^WIDTH, with bout = the borrow from the top bit.
- Boundary cases:
  - a == b with bin=1 gives diff = all ones, bout=1.
  - a=0 with b=all ones gives diff=1 (0 - 0xFFFF mod 2^16 = 1), bout=1. With bin=1, diff=0 and zero=1.

Decomposition:
- Shared package arith_pkg:
  - NIB=4.
  - State enum {IDLE, RUN, DONE}.
  - Helper function for the counter width, clog2(N).
- One sub-module: nibble_sub4. It is a combinational 4-bit borrow-ripple subtractor with ports (diff[3:0], bout, a[3:0], b[3:0], bin), built from four 1-bit full-subtractor cells.
- seq_sub_ctrl instantiates nibble_sub4 once.

Test Plan:
- Basic: a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid after exactly 4 cycles, diff=0x1000, bout=0, zero=0. in_ready returns to 1 the cycle after the transfer.
- Cross-nibble borrow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0.
- Borrow-in and zero: a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0, zero=1. Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
- Backpressure and busy: hold out_ready=0 for 5 cycles after out_valid -> diff, bout and zero are stable and out_valid stays 1. Pulse in_valid with new operands during RUN and DONE -> ignored and in_ready stays 0. Raise out_ready -> IDLE next cycle.
- Reset: assert rst for 1 cycle on the 2nd RUN cycle -> next cycle out_valid=0, diff=0, in_ready=1. A fresh a=0xFFFF, b=0x0001 -> diff=0xFFFE, bout=0.
- Random: 1000 random a, b, bin with random out_ready stalls -> every result matches the model (a-b-bin) mod 2^16 and its borrow, with exactly one out_valid transfer per accepted input.
